// File: rtl/mem_tile_sram_ctrl.sv
// SRAM tile controller: decodes byte addresses onto stacked macros and
// returns one in-order response per grant through a fall-through FIFO.
module mem_tile_sram_ctrl #(
  parameter int unsigned NumWords    = 512,
  parameter int unsigned DataWidth   = 512,
  parameter int unsigned NumBankRows = 4,
  parameter int unsigned AddrWidth   = 48,
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned SramLatency = 1,
  parameter int unsigned RspDepth    = 2,
  localparam int unsigned BeWidth    = DataWidth / 8,
  localparam int unsigned WordW      = $clog2(NumWords)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  req_i,
  output logic                                  gnt_o,
  input  logic [AddrWidth-1:0]                  addr_i,
  input  logic                                  we_i,
  input  logic [DataWidth-1:0]                  wdata_i,
  input  logic [BeWidth-1:0]                    be_i,
  input  logic [IdWidth-1:0]                    aid_i,
  output logic                                  rvalid_o,
  input  logic                                  rready_i,
  output logic [DataWidth-1:0]                  rdata_o,
  output logic [IdWidth-1:0]                    rid_o,
  output logic                                  err_o,
  output logic [NumBankRows-1:0]                sram_req_o,
  output logic                                  sram_we_o,
  output logic [WordW-1:0]                      sram_addr_o,
  output logic [DataWidth-1:0]                  sram_wdata_o,
  output logic [BeWidth-1:0]                    sram_be_o,
  input  logic [NumBankRows-1:0][DataWidth-1:0] sram_rdata_i
);

  localparam int unsigned OffW = $clog2(BeWidth);
  localparam int unsigned SelW = $clog2(NumBankRows);
  localparam int unsigned HiLsb = OffW + WordW + SelW;
  localparam int unsigned CntW = $clog2(RspDepth + 1);
  localparam int unsigned PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;

  typedef struct packed {
    logic               valid;
    logic               we;
    logic               err;
    logic [SelW-1:0]    sel;
    logic [IdWidth-1:0] id;
  } stage_t;

  typedef struct packed {
    logic                 err;
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
  } rsp_t;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RspDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  logic [SelW-1:0] sel;
  logic            oor;
  logic            unused_offset;

  stage_t pipe_q [SramLatency];
  stage_t last;
  rsp_t   fifo_q [RspDepth];
  rsp_t   in_rsp;
  rsp_t   head;

  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] fifo_cnt_q;
  logic [CntW-1:0] out_cnt_q;

  logic fifo_empty;
  logic pop;
  logic push;
  logic fifo_pop;

  assign sel           = addr_i[OffW+WordW +: SelW];
  assign oor           = |addr_i[AddrWidth-1:HiLsb];
  assign unused_offset = ^addr_i[OffW-1:0];

  // Credit is taken from the registered count only, so a pop never
  // grants in the same cycle.
  assign gnt_o = req_i && !rst_i && (out_cnt_q < CntW'(RspDepth));

  assign sram_we_o    = gnt_o && !oor && we_i;
  assign sram_addr_o  = addr_i[OffW +: WordW];
  assign sram_wdata_o = wdata_i;
  assign sram_be_o    = be_i;

  // One-hot macro enable for in-range grants.
  always_comb begin
    sram_req_o = '0;
    if (gnt_o && !oor) sram_req_o[sel] = 1'b1;
  end

  // Request metadata follows the macro read latency.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SramLatency; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{valid: gnt_o, we: we_i, err: oor, sel: sel, id: aid_i};
      for (int i = 1; i < SramLatency; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign last = pipe_q[SramLatency-1];

  // Response formed at the last stage; read data exists only this cycle.
  always_comb begin
    in_rsp      = '0;
    in_rsp.err  = last.err;
    in_rsp.id   = last.id;
    if (!last.we && !last.err) in_rsp.data = sram_rdata_i[last.sel];
  end

  assign fifo_empty = (fifo_cnt_q == '0);
  assign head       = fifo_empty ? in_rsp : fifo_q[rd_ptr_q];
  assign rvalid_o   = !fifo_empty || last.valid;
  assign pop        = rvalid_o && rready_i;
  assign fifo_pop   = pop && !fifo_empty;
  assign push       = last.valid && !(fifo_empty && pop);

  assign rdata_o = rvalid_o ? head.data : '0;
  assign rid_o   = rvalid_o ? head.id : '0;
  assign err_o   = rvalid_o && head.err;

  // FIFO payload storage needs no reset; validity lives in the count.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= in_rsp;
  end

  // FIFO pointers, FIFO occupancy and outstanding-response credit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      out_cnt_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (fifo_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      fifo_cnt_q <= fifo_cnt_q + CntW'(push) - CntW'(fifo_pop);
      out_cnt_q  <= out_cnt_q + CntW'(gnt_o) - CntW'(pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    push |-> (fifo_cnt_q < CntW'(RspDepth) || fifo_pop));

  a_credit_range: assert property (@(posedge clk_i) disable iff (rst_i)
    out_cnt_q <= CntW'(RspDepth));

endmodule

// File: tb/tb_mem_tile_sram_ctrl.sv
// Scoreboard bench for mem_tile_sram_ctrl: byte-level reference memory,
// in-order expected-response queue, plus a latency-2 streaming instance.
module tb_mem_tile_sram_ctrl;

  localparam int NW  = 512;
  localparam int DW  = 512;
  localparam int NB  = 4;
  localparam int AW  = 48;
  localparam int IW  = 4;
  localparam int BE  = DW / 8;
  localparam int LAT = 1;
  localparam int DEP = 2;
  localparam int L2  = 2;
  localparam int D2  = 3;
  localparam int MACRO_BYTES = NW * BE;
  localparam longint TOP = longint'(NB) * NW * BE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  logic          req, gnt, we, rvalid, rready, err;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;
  logic [BE-1:0] be;
  logic [IW-1:0] aid, rid;
  logic [NB-1:0] sreq;
  logic          swe;
  logic [8:0]    saddr;
  logic [DW-1:0] swdata;
  logic [BE-1:0] sbe;
  logic [NB-1:0][DW-1:0] srdata;

  mem_tile_sram_ctrl #(
    .NumWords(NW), .DataWidth(DW), .NumBankRows(NB), .AddrWidth(AW),
    .IdWidth(IW), .SramLatency(LAT), .RspDepth(DEP)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr),
    .we_i(we), .wdata_i(wdata), .be_i(be), .aid_i(aid),
    .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rid_o(rid),
    .err_o(err), .sram_req_o(sreq), .sram_we_o(swe), .sram_addr_o(saddr),
    .sram_wdata_o(swdata), .sram_be_o(sbe), .sram_rdata_i(srdata)
  );

  // Word-organised macro models with one cycle of read latency.
  logic [DW-1:0] mem [NB][NW];
  always @(posedge clk)
    for (int b = 0; b < NB; b++)
      if (sreq[b]) begin
        if (swe) begin
          for (int k = 0; k < BE; k++)
            if (sbe[k]) mem[b][saddr][k*8 +: 8] <= swdata[k*8 +: 8];
        end else begin
          srdata[b] <= mem[b][saddr];
        end
      end

  // Reference: flat byte-addressed memory and in-order expected responses.
  byte unsigned refm [longint];
  typedef struct {
    logic [IW-1:0] id;
    logic          err;
    logic [DW-1:0] data;
    int            g;
  } exp_t;
  exp_t q[$];
  int   last_pop = -100;

  exp_t          e;
  int            osd, due;
  bit            inr;
  longint        base;
  logic [NB-1:0] exp_sreq;

  always @(negedge clk) begin
    if (!rst) begin
      osd = q.size();
      chk(gnt == (req && osd < DEP), "gnt", gnt, req && osd < DEP);
      if (osd == 0) begin
        chk(!rvalid, "spurious_rvalid", rvalid, 0);
      end else begin
        e   = q[0];
        due = (e.g + LAT > last_pop + 1) ? e.g + LAT : last_pop + 1;
        if (cyc < due) begin
          chk(!rvalid, "early_rvalid", rvalid, 0);
        end else if (!rvalid) begin
          chk(1'b0, "late_rvalid", 0, 1);
        end else begin
          chk(rid == e.id, "rid", rid, e.id);
          chk(err == e.err, "err", err, e.err);
          chk(rdata == e.data, "rdata", rdata, e.data);
          if (rready) begin
            e = q.pop_front();
            last_pop = cyc;
          end
        end
      end
      if (req && gnt) begin
        inr      = longint'(addr) < TOP;
        exp_sreq = '0;
        if (inr) exp_sreq[int'(longint'(addr) / MACRO_BYTES)] = 1'b1;
        chk(sreq == exp_sreq, "sram_req", sreq, exp_sreq);
        chk(swe == (we && inr), "sram_we", swe, we && inr);
        if (inr)
          chk(saddr == 9'((longint'(addr) / BE) % NW), "sram_addr", saddr,
              9'((longint'(addr) / BE) % NW));
        e.id   = aid;
        e.err  = !inr;
        e.g    = cyc;
        e.data = '0;
        if (inr) begin
          base = longint'(addr) & ~longint'(BE - 1);
          for (int k = 0; k < BE; k++)
            if (we) begin
              if (be[k]) refm[base + k] = wdata[k*8 +: 8];
            end else if (refm.exists(base + k)) begin
              e.data[k*8 +: 8] = refm[base + k];
            end
        end
        q.push_back(e);
      end else begin
        chk(sreq == '0 && !swe, "sram_idle", {sreq, swe}, 0);
      end
    end
  end

  // Latency-2 instance for streaming throughput.
  logic          req2, gnt2, rvalid2, err2, swe2;
  logic [AW-1:0] addr2;
  logic [IW-1:0] aid2, rid2;
  logic [DW-1:0] rdata2, swdata2;
  logic [BE-1:0] sbe2;
  logic [NB-1:0] sreq2;
  logic [8:0]    saddr2;
  logic [NB-1:0][DW-1:0] s1, s2;

  mem_tile_sram_ctrl #(
    .NumWords(NW), .DataWidth(DW), .NumBankRows(NB), .AddrWidth(AW),
    .IdWidth(IW), .SramLatency(L2), .RspDepth(D2)
  ) dut2 (
    .clk_i(clk), .rst_i(rst), .req_i(req2), .gnt_o(gnt2), .addr_i(addr2),
    .we_i(1'b0), .wdata_i('0), .be_i('0), .aid_i(aid2),
    .rvalid_o(rvalid2), .rready_i(1'b1), .rdata_o(rdata2), .rid_o(rid2),
    .err_o(err2), .sram_req_o(sreq2), .sram_we_o(swe2), .sram_addr_o(saddr2),
    .sram_wdata_o(swdata2), .sram_be_o(sbe2), .sram_rdata_i(s2)
  );

  function automatic logic [DW-1:0] pat(input int b, input int w);
    return {16{32'(32'h5A00_0000 + b * 4096 + w)}};
  endfunction

  always @(posedge clk)
    for (int b = 0; b < NB; b++) begin
      if (sreq2[b]) s1[b] <= pat(b, int'(saddr2));
      s2[b] <= s1[b];
    end

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    int            g;
  } e2_t;
  e2_t q2[$];
  e2_t e2;

  always @(negedge clk) begin
    if (!rst) begin
      if (q2.size() > 0 && cyc == q2[0].g + L2) begin
        e2 = q2.pop_front();
        chk(rvalid2, "l2_rvalid", rvalid2, 1);
        chk(rid2 == e2.id, "l2_rid", rid2, e2.id);
        chk(rdata2 == e2.data && !err2, "l2_rdata", rdata2, e2.data);
      end else if (rvalid2) begin
        chk(1'b0, "l2_rvalid_off", 1, 0);
      end
      if (req2) begin
        chk(gnt2, "l2_stream_gnt", gnt2, 1);
        e2.id   = aid2;
        e2.data = pat(int'(addr2) / MACRO_BYTES, (int'(addr2) / BE) % NW);
        e2.g    = cyc;
        if (gnt2) q2.push_back(e2);
      end
    end
  end

  task automatic issue(input logic [AW-1:0] a, input bit w,
                       input logic [DW-1:0] d, input logic [BE-1:0] b,
                       input logic [IW-1:0] id);
    bit g = 1'b0;
    req = 1'b1; addr = a; we = w; wdata = d; be = b; aid = id;
    for (int t = 0; t < 100 && !g; t++) begin
      @(negedge clk);
      g = gnt;
      @(posedge clk);
      #1;
    end
    if (!g) chk(1'b0, "grant_timeout", 0, 1);
    req = 1'b0;
    we  = 1'b0;
  endtask

  task automatic drain(input int lim);
    int t = 0;
    while (q.size() != 0 && t < lim) begin
      @(posedge clk);
      t++;
    end
    if (q.size() != 0) chk(1'b0, "drain_timeout", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  bit done;
  int r, bk, wd;
  logic [AW-1:0] ra;

  initial begin
    for (int b = 0; b < NB; b++)
      for (int w = 0; w < NW; w++) mem[b][w] = '0;
    req = 1'b1; addr = '0; we = 1'b1; wdata = '1; be = '1; aid = '0;
    rready = 1'b0; req2 = 1'b0; addr2 = '0; aid2 = '0;
    repeat (3) @(posedge clk);
    #2;
    chk(!gnt, "rst_gnt", gnt, 0);
    chk(!rvalid, "rst_rvalid", rvalid, 0);
    chk(sreq == '0, "rst_sram_req", sreq, 0);
    chk(!swe, "rst_sram_we", swe, 0);
    chk(rdata == '0, "rst_rdata", rdata, 0);
    chk(rid == '0 && !err, "rst_rid_err", {rid, err}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0; req = 1'b0; we = 1'b0;

    rready = 1'b1;
    issue(48'h40, 1'b1, {64{8'hA5}}, '1, 4'd3);
    issue(48'h40, 1'b0, '0, '0, 4'd5);
    drain(20);

    issue(48'h8000, 1'b1, {16{32'hC0DE_0001}}, '1, 4'd1);
    issue(48'h0, 1'b1, {16{32'h0BAD_0000}}, '1, 4'd2);
    issue(48'h8000, 1'b0, '0, '0, 4'd4);
    drain(20);

    rready = 1'b0;
    fork
      begin
        issue(48'h40, 1'b0, '0, '0, 4'd0);
        issue(48'h8000, 1'b0, '0, '0, 4'd1);
        issue(48'h100, 1'b0, '0, '0, 4'd2);
      end
      begin
        repeat (6) @(posedge clk);
        #1 rready = 1'b1;
      end
    join
    drain(20);

    issue(48'h20000, 1'b0, '0, '0, 4'd7);
    issue(48'h20040, 1'b1, '1, '1, 4'd8);
    issue(48'h40, 1'b0, '0, '0, 4'd9);
    drain(20);

    rready = 1'b0;
    issue(48'h40, 1'b0, '0, '0, 4'd9);
    issue(48'h8000, 1'b0, '0, '0, 4'd10);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; req = 1'b1;
    #1;
    chk(!rvalid, "midrst_rvalid", rvalid, 0);
    chk(!gnt, "midrst_gnt", gnt, 0);
    chk(sreq == '0, "midrst_sram_req", sreq, 0);
    q.delete();
    last_pop = -100;
    @(posedge clk);
    #1;
    rst = 1'b0; req = 1'b0; rready = 1'b1;
    issue(48'h8000, 1'b0, '0, '0, 4'd11);
    drain(20);

    for (int i = 0; i < 8; i++) begin
      req2  = 1'b1;
      addr2 = AW'((i % NB) * MACRO_BYTES + i * BE);
      aid2  = IW'(i);
      @(posedge clk);
      #1;
    end
    req2 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk(q2.size() == 0, "l2_drain", q2.size(), 0);

    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          r = $urandom % 16;
          if (r == 0) begin
            ra = AW'(1) << $urandom_range(17, AW - 1);
          end else begin
            bk = $urandom % NB;
            wd = $urandom % 8;
            ra = AW'(bk * MACRO_BYTES + wd * BE + ($urandom % BE));
          end
          issue(ra, bit'($urandom % 2), {16{$urandom}},
                BE'({$urandom, $urandom}), IW'($urandom));
          if ($urandom % 4 == 0) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 rready = ($urandom % 3) != 0;
        end
      end
    join
    rready = 1'b1;
    drain(50);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    nerr++;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $fatal(1, "watchdog expired");
  end

endmodule
